id_issue_ctl: RTL and testbench

- Decode/issue stage directly upstream of the two-read-port register file. Holds the IF/ID instruction register and decodes source fields onto the regfile read controls (R1/R2/RE1/RE2).
- Tracks in-flight destination registers in a shift-register scoreboard covering EX, MEM and WB. Stalls fetch on any RAW hazard; there is no forwarding path.
- Hands the issued instruction and its destination to EX.

---
 rtl/dlx_pkg.sv | 42 ++++
 rtl/id_decode.sv | 50 +++++
 rtl/id_issue_ctl.sv | 115 +++++++++++
 tb/tb_id_issue_ctl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, instruction field positions and class helpers.
package dlx_pkg;

    localparam int IR_W  = 32;
    localparam int REG_W = 5;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS1_MSB = 25;
    localparam int RS1_LSB = 21;
    localparam int RS2_MSB = 20;
    localparam int RS2_LSB = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;

    // Opcodes
    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_TRAP    = 6'h11;
    localparam logic [5:0] OP_JR      = 6'h12;
    localparam logic [5:0] OP_JALR    = 6'h13;
    localparam logic [5:0] OP_LOAD_LO = 6'h20;
    localparam logic [5:0] OP_LOAD_HI = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LOAD_LO) && (op <= OP_LOAD_HI);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/id_decode.sv
// Source/destination decode of a DLX instruction. Purely combinational.
module id_decode
    import dlx_pkg::*;
(
    input  logic [IR_W-1:0]  ir,
    output logic             uses_rs1,
    output logic             uses_rs2,
    output logic [REG_W-1:0] dest
);

    logic [5:0]       op;
    logic [REG_W-1:0] rs2_f;
    logic [REG_W-1:0] rd_f;
    logic             unused_low_bits;

    assign op    = ir[OP_MSB:OP_LSB];
    assign rs2_f = ir[RS2_MSB:RS2_LSB];
    assign rd_f  = ir[RD_MSB:RD_LSB];

    // Immediate/function bits carry no register information.
    assign unused_low_bits = ^ir[RD_LSB-1:0];

    // Classify opcode; I-type ALU (rs1 source, rs2-field destination) is the default.
    // A destination of r0 comes out as 0, which already means "none".
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        dest     = rs2_f;
        if (op == OP_RTYPE) begin
            uses_rs2 = 1'b1;
            dest     = rd_f;
        end else if (is_load(op)) begin
            dest = rs2_f;
        end else if (is_store(op)) begin
            uses_rs2 = 1'b1;
            dest     = '0;
        end else if ((op == OP_BEQZ) || (op == OP_BNEZ) || (op == OP_JR)) begin
            dest = '0;
        end else if ((op == OP_J) || (op == OP_TRAP)) begin
            uses_rs1 = 1'b0;
            dest     = '0;
        end else if (op == OP_JAL) begin
            uses_rs1 = 1'b0;
            dest     = LINK_REG;
        end else if (op == OP_JALR) begin
            dest = LINK_REG;
        end
    end

endmodule

// File: rtl/id_issue_ctl.sv
// Decode/issue stage: IF/ID register, regfile read controls, RAW scoreboard
// over EX/MEM/WB (no forwarding), and issue to EX.
module id_issue_ctl
    import dlx_pkg::*;
#(
    parameter int N          = 32,
    parameter int M          = 5,
    parameter int PIPE_DEPTH = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [N-1:0] IR_IN,
    input  logic         IR_VALID,
    input  logic         FLUSH,
    output logic         ID_STALL,
    output logic [M-1:0] R1,
    output logic [M-1:0] R2,
    output logic         RE1,
    output logic         RE2,
    output logic [N-1:0] EX_IR,
    output logic         EX_VALID,
    output logic [M-1:0] EX_DEST
);

    logic                           id_valid_q, id_valid_d;
    logic [N-1:0]                   id_ir_q, id_ir_d;
    logic [PIPE_DEPTH-1:0]          sb_valid_q, sb_valid_d;
    logic [PIPE_DEPTH-1:0][M-1:0]   sb_dest_q, sb_dest_d;
    logic [N-1:0]                   ex_ir_q, ex_ir_d;
    logic                           ex_valid_q, ex_valid_d;
    logic [M-1:0]                   ex_dest_q, ex_dest_d;

    logic                  uses_rs1, uses_rs2;
    logic [M-1:0]          dest;
    logic [M-1:0]          rs1, rs2;
    logic [PIPE_DEPTH-1:0] slot_hit;
    logic                  hazard, stall, issue;

    id_decode u_decode (
        .ir       (id_ir_q),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .dest     (dest)
    );

    assign rs1 = id_ir_q[RS1_MSB:RS1_LSB];
    assign rs2 = id_ir_q[RS2_MSB:RS2_LSB];

    // One comparator pair per in-flight slot; r0 never matches.
    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_slot
        assign slot_hit[gi] = sb_valid_q[gi] &&
            ((uses_rs1 && (rs1 != '0) && (rs1 == sb_dest_q[gi])) ||
             (uses_rs2 && (rs2 != '0) && (rs2 == sb_dest_q[gi])));
    end

    assign hazard = |slot_hit;
    assign stall  = id_valid_q && hazard && !FLUSH;
    assign issue  = id_valid_q && !hazard && !FLUSH;

    assign ID_STALL = stall;
    assign R1       = rs1;
    assign R2       = rs2;
    assign RE1      = id_valid_q && uses_rs1;
    assign RE2      = id_valid_q && uses_rs2;
    assign EX_IR    = ex_ir_q;
    assign EX_VALID = ex_valid_q;
    assign EX_DEST  = ex_dest_q;

    // Next state: ID register (flush > stall > capture), scoreboard shift, EX handoff.
    always_comb begin
        id_valid_d = id_valid_q;
        id_ir_d    = id_ir_q;
        if (FLUSH) begin
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_valid_d = IR_VALID;
            id_ir_d    = IR_IN;
        end

        // Slot0 gets the issued destination or a bubble; the oldest slot falls off.
        sb_valid_d = {sb_valid_q[PIPE_DEPTH-2:0], issue && (dest != '0)};
        sb_dest_d  = {sb_dest_q[PIPE_DEPTH-2:0], (issue ? dest : {M{1'b0}})};

        ex_ir_d    = ex_ir_q;
        ex_valid_d = 1'b0;
        ex_dest_d  = '0;
        if (issue) begin
            ex_ir_d    = id_ir_q;
            ex_valid_d = 1'b1;
            ex_dest_d  = dest;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            id_valid_q <= 1'b0;
            id_ir_q    <= '0;
            sb_valid_q <= '0;
            sb_dest_q  <= '0;
            ex_ir_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_dest_q  <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_ir_q    <= id_ir_d;
            sb_valid_q <= sb_valid_d;
            sb_dest_q  <= sb_dest_d;
            ex_ir_q    <= ex_ir_d;
            ex_valid_q <= ex_valid_d;
            ex_dest_q  <= ex_dest_d;
        end
    end

endmodule

// File: tb/tb_id_issue_ctl.sv
// Directed bench for id_issue_ctl: reset, issue streams, RAW stalls, r0/link, flush, distance.
module tb_id_issue_ctl;

    logic        clk;
    logic        rst;
    logic [31:0] ir_in;
    logic        ir_valid;
    logic        flush;
    logic        id_stall;
    logic [4:0]  r1, r2;
    logic        re1, re2;
    logic [31:0] ex_ir;
    logic        ex_valid;
    logic [4:0]  ex_dest;

    int total = 0;
    int bad   = 0;

    id_issue_ctl dut (
        .CLK      (clk),
        .RESET    (rst),
        .IR_IN    (ir_in),
        .IR_VALID (ir_valid),
        .FLUSH    (flush),
        .ID_STALL (id_stall),
        .R1       (r1),
        .R2       (r2),
        .RE1      (re1),
        .RE2      (re2),
        .EX_IR    (ex_ir),
        .EX_VALID (ex_valid),
        .EX_DEST  (ex_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // One line per issued instruction
    always @(negedge clk) begin
        if (ex_valid === 1'b1)
            $display("issue ir=%08h dest=%0d t=%0t", ex_ir, ex_dest, $time);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] ir);
        ir_in    = ir;
        ir_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        ir_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Count consecutive sampled cycles with ID_STALL high, bounded.
    task automatic count_stall(output int n);
        n = 0;
        while (id_stall === 1'b1 && n < 10) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd);
        return {6'h00, rs1, rs2, rd, 11'h020};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [15:0] imm);
        return {op, rs1, rs2, imm};
    endfunction

    logic [31:0] add1, add4, sw78, sub4, addx, i1, i2, i3, cons, jal, jr31, lw3, sw3, a0, a6;
    int n;
    int ex_cnt;

    initial begin
        add1 = enc_r(5'd2, 5'd3, 5'd1);          // ADD r1,r2,r3
        add4 = enc_r(5'd5, 5'd6, 5'd4);          // ADD r4,r5,r6
        sw78 = enc_i(6'h2B, 5'd8, 5'd7, 16'h0);  // SW r7,0(r8)
        sub4 = enc_r(5'd1, 5'd5, 5'd4);          // SUB r4,r1,r5
        addx = enc_r(5'd11, 5'd12, 5'd10);       // ADD r10,r11,r12
        i1   = enc_r(5'd5, 5'd6, 5'd4);
        i2   = enc_r(5'd8, 5'd9, 5'd7);
        i3   = enc_r(5'd12, 5'd13, 5'd11);
        cons = enc_r(5'd1, 5'd1, 5'd10);         // ADD r10,r1,r1
        jal  = enc_i(6'h03, 5'd0, 5'd0, 16'h0040);
        jr31 = enc_i(6'h12, 5'd31, 5'd0, 16'h0);
        lw3  = enc_i(6'h23, 5'd2, 5'd3, 16'h0);  // LW r3,0(r2)
        sw3  = enc_i(6'h2B, 5'd9, 5'd3, 16'h4);  // SW r3,4(r9)
        a0   = enc_r(5'd2, 5'd3, 5'd0);          // ADD r0,r2,r3
        a6   = enc_r(5'd0, 5'd0, 5'd6);          // ADD r6,r0,r0

        // Reset held two edges with a valid instruction presented
        rst = 1'b1; flush = 1'b0; ir_valid = 1'b1; ir_in = add1;
        tick(); tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_dest", ex_dest, 0);
        chk("rst_ex_ir", ex_ir, 0);
        chk("rst_re1", re1, 0);
        chk("rst_re2", re2, 0);
        chk("rst_stall", id_stall, 0);
        chk("rst_r1", r1, 0);
        rst = 1'b0;
        ir_in = add4;
        tick();
        chk("rst_first_cap_ex", ex_valid, 0);
        chk("rst_first_cap_re1", re1, 1);
        ir_valid = 1'b0;
        tick();
        chk("rst_first_issue_valid", ex_valid, 1);
        chk("rst_first_issue_ir", ex_ir, add4);
        chk("rst_first_issue_dest", ex_dest, 4);
        idle(4);

        // Independent stream
        feed(add1);
        chk("ind_stall0", id_stall, 0);
        feed(add4);
        chk("ind_v1", ex_valid, 1); chk("ind_d1", ex_dest, 1); chk("ind_stall1", id_stall, 0);
        feed(sw78);
        chk("ind_v2", ex_valid, 1); chk("ind_d2", ex_dest, 4); chk("ind_stall2", id_stall, 0);
        chk("sw_re2", re2, 1);
        ir_valid = 1'b0; tick();
        chk("ind_v3", ex_valid, 1); chk("ind_d3", ex_dest, 0); chk("ind_ir3", ex_ir, sw78);
        tick();
        chk("ind_v4", ex_valid, 0);
        idle(3);

        // RAW on rs1
        feed(add1);
        feed(sub4);
        chk("raw_add_issued", ex_dest, 1);
        chk("raw_r1", r1, 1);
        ir_valid = 1'b0;
        count_stall(n);
        chk("raw_stall_cycles", n, 3);
        chk("raw_re1_after", re1, 1);
        chk("raw_r1_after", r1, 1);
        tick();
        chk("raw_sub_valid", ex_valid, 1);
        chk("raw_sub_ir", ex_ir, sub4);
        chk("raw_sub_dest", ex_dest, 4);
        idle(3);

        // Load -> store dependency through rs2
        feed(lw3);
        chk("lw_re2", re2, 0);
        feed(sw3);
        chk("lw_dest", ex_dest, 3);
        ir_valid = 1'b0;
        count_stall(n);
        chk("lw_sw_stall_cycles", n, 3);
        tick();
        chk("lw_sw_issue", ex_ir, sw3);
        idle(3);

        // r0 never hazards
        feed(a0);
        feed(a6);
        chk("r0_stall", id_stall, 0);
        chk("r0_dest_none", ex_dest, 0);
        chk("r0_valid", ex_valid, 1);
        ir_valid = 1'b0; tick();
        chk("r0_a6_dest", ex_dest, 6);
        idle(3);

        // JAL then JR r31
        feed(jal);
        chk("jal_re1", re1, 0);
        feed(jr31);
        chk("jal_dest", ex_dest, 31);
        chk("jr_re2", re2, 0);
        ir_valid = 1'b0;
        count_stall(n);
        chk("jal_jr_stall_cycles", n, 3);
        tick();
        chk("jr_issue", ex_ir, jr31);
        idle(3);

        // Flush while a dependent SUB is stalled
        feed(add1);
        feed(sub4);
        chk("fl_stalled", id_stall, 1);
        flush = 1'b1; ir_in = addx; ir_valid = 1'b1;
        #1;
        chk("fl_stall_drop", id_stall, 0);
        tick();
        flush = 1'b0; ir_valid = 1'b0;
        chk("fl_re1", re1, 0);
        ex_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (ex_valid === 1'b1) ex_cnt++;
            tick();
        end
        chk("fl_no_issue", ex_cnt, 0);
        idle(2);

        // Distance: two independent in between -> 1 stall
        feed(add1); feed(i1); feed(i2); feed(cons);
        ir_valid = 1'b0;
        count_stall(n);
        chk("dist2_stall_cycles", n, 1);
        tick();
        chk("dist2_issue", ex_ir, cons);
        idle(3);

        // Distance: three independent in between -> no stall
        feed(add1); feed(i1); feed(i2); feed(i3); feed(cons);
        ir_valid = 1'b0;
        count_stall(n);
        chk("dist3_stall_cycles", n, 0);
        tick();
        chk("dist3_issue", ex_ir, cons);
        idle(3);

        // Reset while stalled discards the held instruction
        feed(add1);
        feed(sub4);
        chk("rs_stalled", id_stall, 1);
        rst = 1'b1; ir_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rs_stall_clear", id_stall, 0);
        chk("rs_re1_clear", re1, 0);
        ex_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (ex_valid === 1'b1) ex_cnt++;
            tick();
        end
        chk("rs_no_issue", ex_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
